catch_round_ctrl: RTL

- Round/turn scheduler for the 4x4 two-player catch game datapath.
- Collects one direction per player per turn via valid/ready handshakes and issues a combined 4-bit move plus a one-cycle step enable to the game.
- Samples the game's catch flag, keeps per-player scores, restarts the game between rounds and declares a match winner.
- Player 1 is the evader, starting at (3,3); player 2 is the chaser, starting at (0,0).

---
 rtl/catch_round_ctrl_if.sv | 24 ++
 rtl/catch_round_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/catch_round_ctrl_if.sv
// Player handshake and game-side signals for the catch round controller.
// master: the controller; slave: the players plus the game datapath.
interface catch_round_ctrl_if;
    logic       p1_valid;
    logic [1:0] p1_dir;
    logic       p1_ready;
    logic       p2_valid;
    logic [1:0] p2_dir;
    logic       p2_ready;
    logic [3:0] yon;
    logic       step;
    logic       game_rst;
    logic       durum;

    modport master (
        input  p1_valid, p1_dir, p2_valid, p2_dir, durum,
        output p1_ready, p2_ready, yon, step, game_rst
    );

    modport slave (
        output p1_valid, p1_dir, p2_valid, p2_dir, durum,
        input  p1_ready, p2_ready, yon, step, game_rst
    );
endinterface

// File: rtl/catch_round_ctrl.sv
// Turn/round scheduler for the 4x4 two-player catch game: collects one direction per
// player per turn, steps the game, scores each round and declares the match winner.
module catch_round_ctrl #(
    parameter int unsigned TURN_TIMEOUT = 15,
    parameter int unsigned MAX_MOVES    = 12,
    parameter int unsigned N_ROUNDS     = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    catch_round_ctrl_if.master bus,
    output logic               round_active_o,
    output logic [3:0]         score1_o,
    output logic [3:0]         score2_o,
    output logic [3:0]         round_no_o,
    output logic               done_o,
    output logic [1:0]         winner_o
);
    typedef enum logic [2:0] {
        StIdle, StCollect, StIssue, StCheck, StRoundEnd, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] m1_q, m1_d, m2_q, m2_d;
    logic [1:0] last1_q, last1_d, last2_q, last2_d;
    logic       got1_q, got1_d, got2_q, got2_d;
    logic [7:0] tmo_q, tmo_d, moves_q, moves_d;
    logic [3:0] yon_q, yon_d;
    logic [3:0] score1_q, score1_d, score2_q, score2_d, round_q, round_d;
    logic       done_q, done_d, game_rst_q, game_rst_d;
    logic [1:0] winner_q, winner_d;

    logic       hs1, hs2, timeout, both_in, last_round;
    logic [1:0] m1_sel, m2_sel;
    logic [3:0] round_inc;

    assign bus.p1_ready = (state_q == StCollect) && !got1_q;
    assign bus.p2_ready = (state_q == StCollect) && !got2_q;
    assign bus.yon      = yon_q;
    assign bus.step     = (state_q == StIssue);
    assign bus.game_rst = game_rst_q;

    assign round_active_o = (state_q == StCollect) || (state_q == StIssue) ||
                            (state_q == StCheck);
    assign score1_o   = score1_q;
    assign score2_o   = score2_q;
    assign round_no_o = round_q;
    assign done_o     = done_q;
    assign winner_o   = winner_q;

    assign hs1        = bus.p1_valid && bus.p1_ready;
    assign hs2        = bus.p2_valid && bus.p2_ready;
    assign timeout    = (tmo_q == 8'(TURN_TIMEOUT - 1));
    assign both_in    = (got1_q || hs1) && (got2_q || hs2);
    assign round_inc  = round_q + 4'd1;
    assign last_round = (round_inc == 4'(N_ROUNDS));

    // A handshake landing on the timeout edge beats the last-direction fallback.
    assign m1_sel = got1_q ? m1_q : (hs1 ? bus.p1_dir : last1_q);
    assign m2_sel = got2_q ? m2_q : (hs2 ? bus.p2_dir : last2_q);

    always_comb begin
        state_d    = state_q;
        m1_d       = m1_q;
        m2_d       = m2_q;
        last1_d    = last1_q;
        last2_d    = last2_q;
        got1_d     = got1_q;
        got2_d     = got2_q;
        tmo_d      = tmo_q;
        moves_d    = moves_q;
        yon_d      = yon_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        round_d    = round_q;
        done_d     = done_q;
        winner_d   = winner_q;
        game_rst_d = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    score1_d   = '0;
                    score2_d   = '0;
                    round_d    = '0;
                    done_d     = 1'b0;
                    winner_d   = '0;
                    got1_d     = 1'b0;
                    got2_d     = 1'b0;
                    tmo_d      = '0;
                    moves_d    = '0;
                    game_rst_d = 1'b1;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                tmo_d = tmo_q + 8'd1;
                if (hs1) begin
                    got1_d = 1'b1;
                    m1_d   = bus.p1_dir;
                end
                if (hs2) begin
                    got2_d = 1'b1;
                    m2_d   = bus.p2_dir;
                end
                if (both_in || timeout) begin
                    m1_d    = m1_sel;
                    m2_d    = m2_sel;
                    yon_d   = {m1_sel, m2_sel};
                    state_d = StIssue;
                end
            end
            StIssue: begin
                last1_d = m1_q;
                last2_d = m2_q;
                moves_d = moves_q + 8'd1;
                state_d = StCheck;
            end
            StCheck: begin
                if (bus.durum) begin
                    score2_d = (score2_q == 4'hF) ? score2_q : score2_q + 4'd1;
                    state_d  = StRoundEnd;
                end else if (moves_q == 8'(MAX_MOVES)) begin
                    score1_d = (score1_q == 4'hF) ? score1_q : score1_q + 4'd1;
                    state_d  = StRoundEnd;
                end else begin
                    got1_d  = 1'b0;
                    got2_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = StCollect;
                end
            end
            StRoundEnd: begin
                round_d = round_inc;
                moves_d = '0;
                if (last_round) begin
                    done_d   = 1'b1;
                    winner_d = (score1_q > score2_q) ? 2'b01 :
                               (score2_q > score1_q) ? 2'b10 : 2'b11;
                    state_d  = StDone;
                end else begin
                    got1_d     = 1'b0;
                    got2_d     = 1'b0;
                    tmo_d      = '0;
                    game_rst_d = 1'b1;
                    state_d    = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            m1_q       <= '0;
            m2_q       <= '0;
            last1_q    <= '0;
            last2_q    <= '0;
            got1_q     <= 1'b0;
            got2_q     <= 1'b0;
            tmo_q      <= '0;
            moves_q    <= '0;
            yon_q      <= '0;
            score1_q   <= '0;
            score2_q   <= '0;
            round_q    <= '0;
            done_q     <= 1'b0;
            winner_q   <= '0;
            game_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m1_q       <= m1_d;
            m2_q       <= m2_d;
            last1_q    <= last1_d;
            last2_q    <= last2_d;
            got1_q     <= got1_d;
            got2_q     <= got2_d;
            tmo_q      <= tmo_d;
            moves_q    <= moves_d;
            yon_q      <= yon_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            round_q    <= round_d;
            done_q     <= done_d;
            winner_q   <= winner_d;
            game_rst_q <= game_rst_d;
        end
    end
endmodule
